// File: rtl/cpu_phase_gen.sv
// Eight-phase instruction-cycle generator with cpu reset sequencing and run/stop/step control.
// Optional breakpoint compare is enabled by defining CPU_PHASE_BKPT_EN.
module cpu_phase_gen #(
   parameter int RST_HOLD = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             halt,
   input  logic             run_req,
   input  logic             stop_req,
   input  logic             step_req,
`ifdef CPU_PHASE_BKPT_EN
   input  logic             bkpt_en,
   input  logic [CNT_W-1:0] bkpt_cnt,
`endif
   output logic             cpu_rst_,
   output logic             cntrl_clk,
   output logic             alu_clk,
   output logic             fetch,
   output logic             halted,
   output logic             step_done,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {BOOT, IDLE, RUN, STEP, HALTED} state_t;

   state_t           state_reg, state_next;
   logic [2:0]       ph_reg, ph_next;
   logic [3:0]       hold_reg, hold_next;
   logic             cpu_rst_reg, cpu_rst_next;
   logic             cntrl_clk_reg, cntrl_clk_next;
   logic             alu_clk_reg, alu_clk_next;
   logic             fetch_reg, fetch_next;
   logic             halted_reg, halted_next;
   logic             step_done_reg, step_done_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             stop_reg, stop_next;

   logic [CNT_W-1:0] cnt_inc;
   logic             boundary;
   logic             bkpt_hit;

   assign cnt_inc  = cnt_reg + CNT_W'(1);
   assign boundary = (ph_reg == 3'd7);

`ifdef CPU_PHASE_BKPT_EN
   assign bkpt_hit = bkpt_en && (cnt_inc == bkpt_cnt);
`else
   assign bkpt_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_reg     <= BOOT;
         ph_reg        <= 3'd0;
         hold_reg      <= 4'd0;
         cpu_rst_reg   <= 1'b0;
         cntrl_clk_reg <= 1'b0;
         alu_clk_reg   <= 1'b0;
         fetch_reg     <= 1'b1;
         halted_reg    <= 1'b0;
         step_done_reg <= 1'b0;
         cnt_reg       <= '0;
         stop_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ph_reg        <= ph_next;
         hold_reg      <= hold_next;
         cpu_rst_reg   <= cpu_rst_next;
         cntrl_clk_reg <= cntrl_clk_next;
         alu_clk_reg   <= alu_clk_next;
         fetch_reg     <= fetch_next;
         halted_reg    <= halted_next;
         step_done_reg <= step_done_next;
         cnt_reg       <= cnt_next;
         stop_reg      <= stop_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      ph_next        = ph_reg;
      hold_next      = hold_reg;
      cpu_rst_next   = cpu_rst_reg;
      halted_next    = halted_reg;
      step_done_next = 1'b0;
      cnt_next       = cnt_reg;
      stop_next      = stop_reg;

      case (state_reg)
         BOOT: begin
            hold_next = hold_reg + 4'd1;
            if (hold_next == 4'(RST_HOLD)) begin
               cpu_rst_next = 1'b1;
               state_next   = IDLE;
            end
         end
         IDLE: begin
            if (run_req)       state_next = RUN;
            else if (step_req) state_next = STEP;
         end
         RUN: begin
            ph_next = ph_reg + 3'd1;
            if (stop_req) stop_next = 1'b1;
            if (boundary) begin
               cnt_next = cnt_inc;
               // a stop arriving on the boundary clock itself still parks here
               if (halt || stop_reg || stop_req || bkpt_hit) begin
                  state_next  = HALTED;
                  halted_next = 1'b1;
                  stop_next   = 1'b0;
               end
            end
         end
         STEP: begin
            ph_next = ph_reg + 3'd1;
            if (boundary) begin
               cnt_next       = cnt_inc;
               state_next     = HALTED;
               halted_next    = 1'b1;
               step_done_next = 1'b1;
            end
         end
         HALTED: begin
            if (step_req) begin
               state_next  = STEP;
               halted_next = 1'b0;
            end else if (run_req && !halt && !stop_req) begin
               state_next  = RUN;
               halted_next = 1'b0;
            end
         end
         default: state_next = BOOT;
      endcase

      // parked states hold ph at 0, which decodes to the parked output pattern
      cntrl_clk_next = ph_next[0];
      fetch_next     = ~ph_next[2];
      alu_clk_next   = (ph_next == 3'd6);
   end

   assign cpu_rst_  = cpu_rst_reg;
   assign cntrl_clk = cntrl_clk_reg;
   assign alu_clk   = alu_clk_reg;
   assign fetch     = fetch_reg;
   assign halted    = halted_reg;
   assign step_done = step_done_reg;
   assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Scoreboard bench for cpu_phase_gen: expectations are queued with each stimulus step
// and compared after the following clock edge (or immediately for asynchronous reset).
module tb_cpu_phase_gen;

   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_, halt, run_req, stop_req, step_req;
   logic cpu_rst_, cntrl_clk, alu_clk, fetch, halted, step_done;
   logic [CNT_W-1:0] instr_cnt;
`ifdef CPU_PHASE_BKPT_EN
   logic bkpt_en;
   logic [CNT_W-1:0] bkpt_cnt;
`endif

   cpu_phase_gen #(.RST_HOLD(4), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .halt      (halt),
      .run_req   (run_req),
      .stop_req  (stop_req),
      .step_req  (step_req),
`ifdef CPU_PHASE_BKPT_EN
      .bkpt_en   (bkpt_en),
      .bkpt_cnt  (bkpt_cnt),
`endif
      .cpu_rst_  (cpu_rst_),
      .cntrl_clk (cntrl_clk),
      .alu_clk   (alu_clk),
      .fetch     (fetch),
      .halted    (halted),
      .step_done (step_done),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   localparam int S_RST = 0, S_HALTED = 1, S_DONE = 2, S_CNT = 3, S_CLKS = 4;

   typedef struct {
      string       tag;
      int          sel;
      logic [15:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("[%0t] ok   %-12s obs=%0h exp=%0h", $time, tag, obs, exp);
      end else begin
         $display("[%0t] FAIL %-12s actual=%0h required=%0h", $time, tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         S_RST:    return {15'd0, cpu_rst_};
         S_HALTED: return {15'd0, halted};
         S_DONE:   return {15'd0, step_done};
         S_CNT:    return {12'd0, instr_cnt};
         default:  return {13'd0, cntrl_clk, alu_clk, fetch};
      endcase
   endfunction

   // {cntrl_clk, alu_clk, fetch} for a given phase
   function automatic logic [15:0] clk_exp(input int ph);
      logic [2:0] p;
      p = 3'(ph);
      return {13'd0, p[0], (p == 3'd6), ~p[2]};
   endfunction

   task automatic push(input string tag, input int sel, input logic [15:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ = 1'b0; halt = 1'b0; run_req = 1'b0; stop_req = 1'b0; step_req = 1'b0;
`ifdef CPU_PHASE_BKPT_EN
      bkpt_en = 1'b0; bkpt_cnt = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      push("rst_cpu_rst", S_RST, 0);
      push("rst_clks", S_CLKS, 16'b001);
      push("rst_halted", S_HALTED, 0);
      push("rst_done", S_DONE, 0);
      push("rst_cnt", S_CNT, 0);
      drain();

      // reset release: cpu_rst_ rises on the fourth edge
      rst_ = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         push("boot_hold", S_RST, 0);
         tick();
      end
      push("boot_rel", S_RST, 1);
      push("boot_clks", S_CLKS, 16'b001);
      tick();
      push("idle_clks", S_CLKS, 16'b001);
      tick();

      // continuous run: two full instructions
      run_req = 1'b1;
      push("run_entry", S_CLKS, 16'b001);
      tick();
      for (int k = 1; k <= 16; k++) begin
         push("run_clks", S_CLKS, clk_exp(k % 8));
         tick();
      end
      push("run_cnt2", S_CNT, 2);
      drain();

      // halt raised at ph=3 parks at the next wrap
      for (int k = 1; k <= 3; k++) begin
         push("pre_halt", S_CLKS, clk_exp(k));
         tick();
      end
      halt = 1'b1;
      for (int k = 4; k <= 7; k++) begin
         push("halt_wait", S_HALTED, 0);
         push("halt_clks", S_CLKS, clk_exp(k));
         tick();
      end
      push("halt_park", S_HALTED, 1);
      push("halt_cnt", S_CNT, 3);
      push("halt_clks0", S_CLKS, 16'b001);
      tick();
      for (int k = 0; k < 3; k++) begin
         push("halt_ignrun", S_HALTED, 1);
         push("halt_hold", S_CLKS, 16'b001);
         push("halt_cnt_h", S_CNT, 3);
         tick();
      end

      // single step
      halt = 1'b0; run_req = 1'b0; step_req = 1'b1;
      push("step_leave", S_HALTED, 0);
      push("step_entry", S_CLKS, 16'b001);
      tick();
      step_req = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         push("step_clks", S_CLKS, clk_exp(k));
         push("step_nodone", S_DONE, 0);
         tick();
      end
      push("step_done", S_DONE, 1);
      push("step_halted", S_HALTED, 1);
      push("step_cnt", S_CNT, 4);
      push("step_park", S_CLKS, 16'b001);
      tick();
      push("step_pulse", S_DONE, 0);
      push("step_stay", S_HALTED, 1);
      tick();

      // stop pulse at ph=1 waits for the boundary
      run_req = 1'b1;
      push("stop_runent", S_HALTED, 0);
      tick();
      run_req = 1'b0;
      push("stop_ph1", S_CLKS, clk_exp(1));
      tick();
      stop_req = 1'b1;
      push("stop_ph2", S_CLKS, clk_exp(2));
      push("stop_notyet", S_HALTED, 0);
      tick();
      stop_req = 1'b0;
      for (int k = 3; k <= 7; k++) begin
         push("stop_wait", S_HALTED, 0);
         push("stop_clks", S_CLKS, clk_exp(k));
         tick();
      end
      push("stop_park", S_HALTED, 1);
      push("stop_cnt", S_CNT, 5);
      tick();

      // run and step together from HALTED: step wins
      run_req = 1'b1; step_req = 1'b1;
      push("rs_leave", S_HALTED, 0);
      tick();
      step_req = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         push("rs_clks", S_CLKS, clk_exp(k));
         tick();
      end
      push("rs_done", S_DONE, 1);
      push("rs_halted", S_HALTED, 1);
      push("rs_cnt", S_CNT, 6);
      tick();

      // run and stop together in HALTED: stop wins
      stop_req = 1'b1;
      push("rstop_stay", S_HALTED, 1);
      push("rstop_done", S_DONE, 0);
      tick();
      stop_req = 1'b0;
      push("rerun", S_HALTED, 0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         push("pre_rst", S_CLKS, clk_exp(k));
         tick();
      end

      // asynchronous reset at ph=5
      rst_ = 1'b0;
      #1;
      push("arst_cpu", S_RST, 0);
      push("arst_clks", S_CLKS, 16'b001);
      push("arst_cnt", S_CNT, 0);
      push("arst_halted", S_HALTED, 0);
      drain();

      // counter wrap over 16 instructions
      run_req = 1'b0;
      rst_ = 1'b1;
      repeat (3) tick();
      push("boot2_rel", S_RST, 1);
      tick();
      run_req = 1'b1;
      tick();
      repeat (120) tick();
      push("wrap_15", S_CNT, 15);
      drain();
      repeat (8) tick();
      push("wrap_0", S_CNT, 0);
      push("wrap_run", S_HALTED, 0);
      drain();

`ifdef CPU_PHASE_BKPT_EN
      bkpt_en = 1'b1; bkpt_cnt = 4'd3;
      repeat (23) tick();
      push("bkpt_pre", S_CNT, 2);
      push("bkpt_prehlt", S_HALTED, 0);
      drain();
      push("bkpt_cnt", S_CNT, 3);
      push("bkpt_halted", S_HALTED, 1);
      push("bkpt_clks", S_CLKS, 16'b001);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_phase_gen.md
Name: cpu_phase_gen

Overview:
- Timing front end that sits directly upstream of the cpu top.
- Divides the single master clock into the 8-phase instruction cycle the cpu consumes (cntrl_clk, alu_clk, fetch).
- Sequences cpu reset release and run/stop/single-step control from a debug host.
- Parks the cpu cleanly at an instruction boundary when the cpu raises halt.

Parameters:
RST_HOLD, 4, master clk cycles cpu_rst_ stays low after rst_ deasserts (legal 1..15)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  master clock; every flop rising-edge
rst_  input  1  asynchronous active-low reset
halt  input  1  halt from cpu control
run_req  input  1  host: run continuously (level, sampled each clk)
stop_req  input  1  host: stop at next instruction boundary (one-clk pulse)
step_req  input  1  host: execute exactly one instruction (one-clk pulse)
cpu_rst_  output  1  reset to cpu, active-low
cntrl_clk  output  1  control/pc/mem clock to cpu
alu_clk  output  1  alu clock to cpu
fetch  output  1  address-mux select to cpu
halted  output  1  high while parked in HALTED
step_done  output  1  one-clk pulse when a step completes
instr_cnt  output  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- Reset (rst_ low, asynchronous, immediate): state=BOOT, ph=0, hold counter=0, cpu_rst_=0, cntrl_clk=0, alu_clk=0, fetch=1, halted=0, step_done=0, instr_cnt=0, stop pending=0. Reset mid-instruction aborts immediately; no boundary wait.
- Phase counter ph[2:0] advances +1 per clk only in RUN or STEP; wraps 7->0. Wrap edge = instruction boundary.
- Registered outputs, updated on the same edge as ph, decoded from the new ph: cntrl_clk=ph[0]; fetch=~ph[2] (high ph 0-3); alu_clk=(ph==6). Outputs are glitch-free flop outputs.
- Parked states (BOOT, IDLE, HALTED): ph held 0, cntrl_clk=0, alu_clk=0, fetch=1.
- BOOT: cpu_rst_ low; the hold counter counts clk edges after rst_ deasserts. The edge on which the counter reaches RST_HOLD sets cpu_rst_=1 and state->IDLE. All host requests are ignored in BOOT.
- IDLE: run_req=1 -> RUN; else step_req -> STEP. Entry edge changes only the state; ph stays 0 and advances from the following edge.
- RUN: at each boundary, if halt=1 or a stop is pending -> HALTED (ph=0, halted=1); otherwise continue. A stop_req pulse during RUN sets stop pending, cleared on entering HALTED. Deasserting run_req does not stop.
- HALTED: step_req -> STEP; run_req=1 with halt=0 -> RUN; run_req with halt=1 is ignored. run_req and step_req together: step wins. run_req and stop_req in the same clk: stop wins (remain/enter HALTED).
- STEP: runs one full 8-phase instruction. At the boundary -> HALTED, halted=1, step_done=1 for exactly that one clk. step_req and stop_req during STEP are ignored.
- halted deasserts on the edge that leaves HALTED.
- instr_cnt increments by 1 at every boundary edge (RUN or STEP), including the boundary that enters HALTED. It wraps 2^CNT_W-1 -> 0 without a flag.

Optional Feature:
CPU_PHASE_BKPT_EN
- Defined: extra inputs bkpt_en (1) and bkpt_cnt (CNT_W). In RUN, if bkpt_en=1 and the post-increment instr_cnt equals bkpt_cnt at a boundary -> HALTED, same as a stop. Priority: halt = stop = breakpoint, all yield HALTED.
- Undefined: ports absent; no breakpoint logic.

Test Plan:
- Reset release, RST_HOLD=4: rst_ rises at edge 0 -> cpu_rst_=1 after edge 4; state IDLE; all clock outputs parked (0,0,1).
- run_req=1 held, halt=0, 16 clk after entry -> cntrl_clk toggles every clk; alu_clk high only at ph=6 (2 pulses); fetch high 4 / low 4; instr_cnt=2.
- RUN with halt driven 1 at ph=3 -> continues to ph=7, parks at wrap; halted=1; instr_cnt +1; a later run_req is ignored while halt=1.
- From HALTED, step_req pulse -> exactly 8 phases run; step_done one clk at boundary; halted=1 again; instr_cnt +1.
- stop_req pulse at ph=1 in RUN -> stops at next boundary, not immediately; rst_ low at ph=5 -> all outputs reset in the same cycle.
- CNT_W=4 preloaded run of 16 instructions -> instr_cnt wraps 15->0; with CPU_PHASE_BKPT_EN, bkpt_cnt=3 -> HALTED with instr_cnt=3.
